// File: rtl/majority_pkg.sv
// Shared types and width helpers for the serial majority-vote sequencer.
package majority_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int CNT_W(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int IDX_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/majority_vote_seq.sv
// Serial majority-vote sequencer: captures N votes, scans one bit per clock,
// optionally stops once the outcome is decided, and holds the result until ack.
module majority_vote_seq
    import majority_pkg::*;
#(
    parameter int N          = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N-1:0]       votes,
    input  logic               ack,
    output logic               busy,
    output logic               done,
    output logic               one,
    output logic [CNT_W(N)-1:0] ones_cnt
);

    localparam int CW   = CNT_W(N);
    localparam int IW   = IDX_W(N);
    localparam int HALF = N / 2;

    state_t         state, next_state;
    logic [N-1:0]   vec;
    logic [CW-1:0]  cnt;
    logic [IW-1:0]  idx;
    logic           one_q;

    logic [CW-1:0]  cnt_n;
    int             rem;
    logic           decided;
    logic           decided_val;

    // The captured vector shifts right each SCAN cycle, so the bit at
    // position idx of the original capture is always vec[0].
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_n       = cnt + CW'(vec[0]);
        rem         = N - 1 - int'(idx);
        decided     = 1'b0;
        decided_val = 1'b0;
        if (EARLY_EXIT && int'(cnt_n) > HALF) begin
            decided     = 1'b1;
            decided_val = 1'b1;
        end else if (EARLY_EXIT && int'(cnt_n) + rem <= HALF) begin
            decided     = 1'b1;
        end else if (idx == IW'(N - 1)) begin
            decided     = 1'b1;
            decided_val = (int'(cnt_n) > HALF);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start)   next_state = SCAN;
            SCAN:    if (decided) next_state = DONE;
            DONE:    if (ack)     next_state = IDLE;
            default:              next_state = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        one      = one_q;
        ones_cnt = cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the capture register is a plain flop bank, so it is reset along with the control state.
            vec   <= '0;
            cnt   <= '0;
            idx   <= '0;
            one_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        vec   <= votes;
                        cnt   <= '0;
                        idx   <= '0;
                        one_q <= 1'b0;
                    end
                end
                SCAN: begin
                    cnt <= cnt_n;
                    vec <= vec >> 1;
                    if (decided) one_q <= decided_val;
                    else         idx   <= idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_majority_vote_seq.sv
// Self-checking bench: four parameterisations share a clock/reset and a selected
// stimulus channel; expected results go through a scoreboard queue.
module tb_majority_vote_seq;

    typedef struct {
        logic       one;
        logic [3:0] cnt;
        int         lat;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_bus;
    logic       ack_bus;
    logic [7:0] votes_bus;
    logic [1:0] sel;

    logic       busy0, done0, one0;  logic [3:0] cnt0;
    logic       busy1, done1, one1;  logic [3:0] cnt1;
    logic       busy2, done2, one2;  logic [0:0] cnt2;
    logic       busy3, done3, one3;  logic [2:0] cnt3;

    logic       busy_s, done_s, one_s;
    logic [3:0] cnt_s;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    // 0: N=8 early exit, 1: N=8 full scan, 2: N=1, 3: N=7
    majority_vote_seq #(.N(8), .EARLY_EXIT(1'b1)) u_n8_ee (
        .clk(clk), .rst_n(rst_n), .start(start_bus && sel == 2'd0), .votes(votes_bus),
        .ack(ack_bus && sel == 2'd0), .busy(busy0), .done(done0), .one(one0), .ones_cnt(cnt0));
    majority_vote_seq #(.N(8), .EARLY_EXIT(1'b0)) u_n8_full (
        .clk(clk), .rst_n(rst_n), .start(start_bus && sel == 2'd1), .votes(votes_bus),
        .ack(ack_bus && sel == 2'd1), .busy(busy1), .done(done1), .one(one1), .ones_cnt(cnt1));
    majority_vote_seq #(.N(1), .EARLY_EXIT(1'b1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .start(start_bus && sel == 2'd2), .votes(votes_bus[0:0]),
        .ack(ack_bus && sel == 2'd2), .busy(busy2), .done(done2), .one(one2), .ones_cnt(cnt2));
    majority_vote_seq #(.N(7), .EARLY_EXIT(1'b1)) u_n7 (
        .clk(clk), .rst_n(rst_n), .start(start_bus && sel == 2'd3), .votes(votes_bus[6:0]),
        .ack(ack_bus && sel == 2'd3), .busy(busy3), .done(done3), .one(one3), .ones_cnt(cnt3));

    always_comb begin
        busy_s = busy0; done_s = done0; one_s = one0; cnt_s = cnt0;
        case (sel)
            2'd1: begin busy_s = busy1; done_s = done1; one_s = one1; cnt_s = cnt1; end
            2'd2: begin busy_s = busy2; done_s = done2; one_s = one2; cnt_s = 4'(cnt2); end
            2'd3: begin busy_s = busy3; done_s = done3; one_s = one3; cnt_s = 4'(cnt3); end
            default: ;
        endcase
    end

    function automatic int n_of(input logic [1:0] s);
        case (s)
            2'd2:    return 1;
            2'd3:    return 7;
            default: return 8;
        endcase
    endfunction

    // Behavioural reference of the scan rules, used for random vectors.
    function automatic exp_t model(input logic [1:0] s, input logic [7:0] v);
        exp_t e;
        int   n  = n_of(s);
        bit   ee = (s != 2'd1);
        int   c  = 0;
        e.name = "rand";
        for (int i = 0; i < n; i++) begin
            c += int'(v[i]);
            if (ee && c > n / 2) begin
                e.one = 1'b1; e.cnt = 4'(c); e.lat = i + 1; return e;
            end
            if (ee && c + (n - 1 - i) <= n / 2) begin
                e.one = 1'b0; e.cnt = 4'(c); e.lat = i + 1; return e;
            end
        end
        e.one = (c > n / 2); e.cnt = 4'(c); e.lat = n;
        return e;
    endfunction

    function automatic exp_t mk(input logic o, input logic [3:0] c, input int l, input string nm);
        exp_t e;
        e.one = o; e.cnt = c; e.lat = l; e.name = nm;
        return e;
    endfunction

    // Drives start with the given vector and returns just after the accepting edge.
    task automatic begin_vote(input logic [1:0] s, input logic [7:0] v, input exp_t e);
        @(negedge clk);
        sel       = s;
        votes_bus = v;
        start_bus = 1'b1;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic finish_vote(input bit hold, input bit toggle, input bit do_ack);
        exp_t e;
        int   cycles = 0;
        @(negedge clk);
        if (!hold) start_bus = 1'b0;
        total++;
        if (busy_s !== 1'b1) begin
            bad++;
            $display("FAIL accept_busy: busy=%b want 1", busy_s);
        end
        while (done_s !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (toggle) votes_bus = ~votes_bus;
        end
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty: got done with no expected entry");
            return;
        end
        e = sb.pop_front();
        total++;
        if (done_s !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: done=%b after %0d cycles want 1", e.name, done_s, cycles);
        end
        total++;
        if (cycles != e.lat) begin
            bad++;
            $display("FAIL %s_latency: got %0d want %0d", e.name, cycles, e.lat);
        end
        total++;
        if (one_s !== e.one) begin
            bad++;
            $display("FAIL %s_one: got %b want %b", e.name, one_s, e.one);
        end
        total++;
        if (cnt_s !== e.cnt) begin
            bad++;
            $display("FAIL %s_ones_cnt: got %0d want %0d", e.name, cnt_s, e.cnt);
        end
        if (do_ack) begin
            ack_bus = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ack_bus = 1'b0;
            total++;
            if (busy_s !== 1'b0 || done_s !== 1'b0) begin
                bad++;
                $display("FAIL %s_after_ack: busy=%b done=%b want 0 0", e.name, busy_s, done_s);
            end
        end
    endtask

    task automatic run_vote(input logic [1:0] s, input logic [7:0] v, input exp_t e);
        begin_vote(s, v, e);
        finish_vote(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_bus = 1'b0; ack_bus = 1'b0; votes_bus = '0; sel = '0;
        #12;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            total++;
            if ({busy_s, done_s, one_s, cnt_s} !== 7'd0) begin
                bad++;
                $display("FAIL reset_outputs sel=%0d: got busy=%b done=%b one=%b cnt=%0d want all 0",
                         s, busy_s, done_s, one_s, cnt_s);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_plan_vectors;
        run_vote(2'd0, 8'hFF, mk(1'b1, 4'd5, 5, "ee_ff"));
        run_vote(2'd0, 8'h00, mk(1'b0, 4'd0, 4, "ee_00"));
        run_vote(2'd0, 8'h0F, mk(1'b0, 4'd4, 8, "ee_tie"));
        run_vote(2'd1, 8'hF8, mk(1'b1, 4'd5, 8, "full_f8"));
        run_vote(2'd1, 8'h0F, mk(1'b0, 4'd4, 8, "full_tie"));
        run_vote(2'd2, 8'h01, mk(1'b1, 4'd1, 1, "n1_one"));
        run_vote(2'd2, 8'h00, mk(1'b0, 4'd0, 1, "n1_zero"));
        run_vote(2'd3, 8'h0F, mk(1'b1, 4'd4, 4, "n7_0f"));
        run_vote(2'd3, 8'h01, mk(1'b0, 4'd1, 5, "n7_01"));
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            logic [1:0] s = (i % 3 == 2) ? 2'd3 : 2'(i % 2);
            logic [7:0] v = 8'($urandom);
            run_vote(s, v, model(s, v));
        end
    endtask

    // start held high across a whole scan while votes toggle, then start+ack in DONE.
    task automatic test_back_to_back;
        begin_vote(2'd0, 8'h0F, mk(1'b0, 4'd4, 8, "hold_start"));
        finish_vote(1'b1, 1'b1, 1'b0);
        votes_bus = 8'hFF;
        ack_bus   = 1'b1;
        sb.push_back(mk(1'b1, 4'd5, 5, "b2b_second"));
        @(posedge clk);
        @(negedge clk);
        ack_bus = 1'b0;
        total++;
        if (busy_s !== 1'b0 || done_s !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle_gap: busy=%b done=%b want 0 0", busy_s, done_s);
        end
        @(posedge clk);
        finish_vote(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_scan;
        @(negedge clk);
        sel = 2'd1; votes_bus = 8'hFF; start_bus = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_bus = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy_s, done_s, one_s, cnt_s} !== 7'd0) begin
            bad++;
            $display("FAIL midscan_reset: busy=%b done=%b one=%b cnt=%0d want all 0",
                     busy_s, done_s, one_s, cnt_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (busy_s !== 1'b0) begin
            bad++;
            $display("FAIL midscan_release_idle: busy=%b want 0", busy_s);
        end
        run_vote(2'd1, 8'hF0, mk(1'b0, 4'd4, 8, "after_reset_f0"));
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_random();
        test_back_to_back();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
